status_tx_fsm: RTL

STATUS_TX_FSM -- requirements
Module: status_tx_fsm

---
 rtl/ocr_pkg.sv | 36 +++
 rtl/result_latch.sv | 42 ++++
 rtl/status_tx_fsm.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ocr_pkg.sv
// Shared types and constants for the OCR controller status interface.
package ocr_pkg;

    // state | meaning
    // S_IDLE   | waiting for a chip-select rising edge, transmitter output idle
    // S_SYNC   | presenting the sync byte
    // S_STATUS | presenting {seq_count, status_code}
    // S_RESULT | presenting {res_valid, 3'b000, res_class}
    // S_CHECK  | presenting the XOR checksum of the three preceding bytes
    // S_PAD    | frame complete, presenting pad bytes until chip-select falls
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_STATUS,
        S_RESULT,
        S_CHECK,
        S_PAD
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] PAD_BYTE_DEFAULT  = 8'h00;

    localparam logic [3:0] STATUS_IDLE   = 4'h0;
    localparam logic [3:0] STATUS_BUSY   = 4'h1;
    localparam logic [3:0] STATUS_RESULT = 4'h8;
    localparam logic [3:0] STATUS_ERROR  = 4'hF;

    function automatic logic [7:0] frame_checksum(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2
    );
        return b0 ^ b1 ^ b2;
    endfunction

endpackage

// File: rtl/result_latch.sv
// Holds the most recent classifier result until cleared.
module result_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic       result_ready,
    input  logic [3:0] result_class,
    input  logic       clear,
    output logic       res_valid,
    output logic [3:0] res_class
);

    logic       res_valid_q, res_valid_d;
    logic [3:0] res_class_q, res_class_d;

    // Clear has priority so a result arriving in the same cycle is discarded.
    always_comb begin
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        if (clear) begin
            res_valid_d = 1'b0;
            res_class_d = 4'h0;
        end else if (result_ready) begin
            res_valid_d = 1'b1;
            res_class_d = result_class;
        end
    end

    // Result hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_class_q <= 4'h0;
        end else begin
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_class = res_class_q;

endmodule

// File: rtl/status_tx_fsm.sv
// Streams a 4-byte status frame to the SPI slave transmitter on each
// chip-select assertion, then pads until chip-select is released.
module status_tx_fsm
    import ocr_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter logic [7:0] PAD_BYTE  = PAD_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs_active,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic [3:0] status_code,
    input  logic       result_ready,
    input  logic [3:0] result_class,
    input  logic       clear,
    output logic       frame_done,
    output logic [3:0] seq_count
);

    tx_state_t  state_q, state_d;
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       frame_done_q, frame_done_d;
    logic [3:0] seq_q, seq_d;
    logic       cs_prev_q, cs_prev_d;
    logic       cs_armed_q, cs_armed_d;
    logic [3:0] snap_status_q, snap_status_d;
    logic [3:0] snap_seq_q, snap_seq_d;
    logic       snap_rv_q, snap_rv_d;
    logic [3:0] snap_cls_q, snap_cls_d;

    logic       res_valid;
    logic [3:0] res_class;
    logic       accept;
    logic       cs_start;
    logic [7:0] byte_status;
    logic [7:0] byte_result;
    logic [7:0] byte_check;

    result_latch u_result_latch (
        .clk          (clk),
        .rst          (rst),
        .result_ready (result_ready),
        .result_class (result_class),
        .clear        (clear),
        .res_valid    (res_valid),
        .res_class    (res_class)
    );

    // cs_armed blocks a frame start until chip-select has been seen low, so a
    // chip-select held high across reset release does not open a frame.
    assign accept      = tx_valid_q & tx_ready;
    assign cs_start    = spi_cs_active & ~cs_prev_q & cs_armed_q;
    assign byte_status = {snap_seq_q, snap_status_q};
    assign byte_result = {snap_rv_q, 3'b000, snap_cls_q};
    assign byte_check  = frame_checksum(SYNC_BYTE, byte_status, byte_result);

    // Next-state and registered-output logic; chip-select loss overrides last.
    always_comb begin
        state_d       = state_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        frame_done_d  = 1'b0;
        seq_d         = seq_q;
        cs_prev_d     = spi_cs_active;
        cs_armed_d    = cs_armed_q | ~spi_cs_active;
        snap_status_d = snap_status_q;
        snap_seq_d    = snap_seq_q;
        snap_rv_d     = snap_rv_q;
        snap_cls_d    = snap_cls_q;

        case (state_q)
            S_IDLE: begin
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
                if (cs_start) begin
                    snap_status_d = status_code;
                    snap_seq_d    = seq_q;
                    snap_rv_d     = res_valid;
                    snap_cls_d    = res_class;
                    state_d       = S_SYNC;
                    tx_valid_d    = 1'b1;
                    tx_data_d     = SYNC_BYTE;
                end
            end
            S_SYNC: begin
                if (accept) begin
                    state_d   = S_STATUS;
                    tx_data_d = byte_status;
                end
            end
            S_STATUS: begin
                if (accept) begin
                    state_d   = S_RESULT;
                    tx_data_d = byte_result;
                end
            end
            S_RESULT: begin
                if (accept) begin
                    state_d   = S_CHECK;
                    tx_data_d = byte_check;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d      = S_PAD;
                    tx_data_d    = PAD_BYTE;
                    frame_done_d = 1'b1;
                    seq_d        = seq_q + 4'd1;
                end
            end
            S_PAD: begin
                if (accept) begin
                    tx_data_d = PAD_BYTE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase

        if ((state_q != S_IDLE) && !spi_cs_active) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
        end
    end

    // State, output and snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            frame_done_q  <= 1'b0;
            seq_q         <= 4'h0;
            cs_prev_q     <= 1'b0;
            cs_armed_q    <= ~spi_cs_active;
            snap_status_q <= 4'h0;
            snap_seq_q    <= 4'h0;
            snap_rv_q     <= 1'b0;
            snap_cls_q    <= 4'h0;
        end else begin
            state_q       <= state_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            frame_done_q  <= frame_done_d;
            seq_q         <= seq_d;
            cs_prev_q     <= cs_prev_d;
            cs_armed_q    <= cs_armed_d;
            snap_status_q <= snap_status_d;
            snap_seq_q    <= snap_seq_d;
            snap_rv_q     <= snap_rv_d;
            snap_cls_q    <= snap_cls_d;
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign frame_done = frame_done_q;
    assign seq_count  = seq_q;

endmodule
